idex_pipe: RTL and testbench

ID/EX pipeline register for the light RV32I core, sitting between decode and execute. It feeds the forwarding unit, the ALU operand muxes and the EX/MEM register. It latches decoded operands and control each cycle and detects load-use hazards against the instruction currently in EX. On a load-use hazard it inserts a bubble and freezes the front end. It also applies external stall/flush and keeps a saturating bubble counter.

---
 rtl/idex_pipe_if.sv | 64 ++++++
 rtl/idex_pipe.sv | 96 +++++++++
 tb/tb_idex_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/idex_pipe_if.sv
// ID/EX pipeline bus: decoded ID-stage fields in, registered EX-stage copies
// and hazard signals out. The slave modport is the pipe register; master is the ID side.
interface idex_pipe_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic              i_idex_Stall;
    logic              i_idex_Flush;
    logic              i_idex_Valid;
    logic [31:0]       i_idex_PC;
    logic [4:0]        i_idex_Rs1;
    logic [4:0]        i_idex_Rs2;
    logic [4:0]        i_idex_Rd;
    logic              i_idex_UseRs1;
    logic              i_idex_UseRs2;
    logic [31:0]       i_idex_RData1;
    logic [31:0]       i_idex_RData2;
    logic [31:0]       i_idex_Imm;
    logic [3:0]        i_idex_AluOp;
    logic              i_idex_AluSrcB;
    logic              i_idex_RegWrEn;
    logic              i_idex_MemWrEn;
    logic              i_idex_MemRdEn;
    logic              i_idex_MemToReg;

    logic              o_idex_Valid;
    logic [31:0]       o_idex_PC;
    logic [4:0]        o_idex_Rs1;
    logic [4:0]        o_idex_Rs2;
    logic [4:0]        o_idex_Rd;
    logic [31:0]       o_idex_RData1;
    logic [31:0]       o_idex_RData2;
    logic [31:0]       o_idex_Imm;
    logic [3:0]        o_idex_AluOp;
    logic              o_idex_AluSrcB;
    logic              o_idex_RegWrEn;
    logic              o_idex_MemWrEn;
    logic              o_idex_MemRdEn;
    logic              o_idex_MemToReg;
    logic              o_idex_LoadUse;
    logic              o_idex_StallID;
    logic [CNT_W-1:0]  o_idex_BubbleCnt;

    modport slave (
        input  i_idex_Stall, i_idex_Flush, i_idex_Valid, i_idex_PC,
               i_idex_Rs1, i_idex_Rs2, i_idex_Rd, i_idex_UseRs1, i_idex_UseRs2,
               i_idex_RData1, i_idex_RData2, i_idex_Imm, i_idex_AluOp, i_idex_AluSrcB,
               i_idex_RegWrEn, i_idex_MemWrEn, i_idex_MemRdEn, i_idex_MemToReg,
        output o_idex_Valid, o_idex_PC, o_idex_Rs1, o_idex_Rs2, o_idex_Rd,
               o_idex_RData1, o_idex_RData2, o_idex_Imm, o_idex_AluOp, o_idex_AluSrcB,
               o_idex_RegWrEn, o_idex_MemWrEn, o_idex_MemRdEn, o_idex_MemToReg,
               o_idex_LoadUse, o_idex_StallID, o_idex_BubbleCnt
    );

    modport master (
        output i_idex_Stall, i_idex_Flush, i_idex_Valid, i_idex_PC,
               i_idex_Rs1, i_idex_Rs2, i_idex_Rd, i_idex_UseRs1, i_idex_UseRs2,
               i_idex_RData1, i_idex_RData2, i_idex_Imm, i_idex_AluOp, i_idex_AluSrcB,
               i_idex_RegWrEn, i_idex_MemWrEn, i_idex_MemRdEn, i_idex_MemToReg,
        input  o_idex_Valid, o_idex_PC, o_idex_Rs1, o_idex_Rs2, o_idex_Rd,
               o_idex_RData1, o_idex_RData2, o_idex_Imm, o_idex_AluOp, o_idex_AluSrcB,
               o_idex_RegWrEn, o_idex_MemWrEn, o_idex_MemRdEn, o_idex_MemToReg,
               o_idex_LoadUse, o_idex_StallID, o_idex_BubbleCnt
    );
endinterface

// File: rtl/idex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, stall/flush and a
// saturating count of inserted bubbles.
module idex_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    idex_pipe_if.slave   bus
);
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_src_b;
        logic        reg_wr_en;
        logic        mem_wr_en;
        logic        mem_rd_en;
        logic        mem_to_reg;
    } idex_t;

    idex_t            r_stage;
    idex_t            w_id;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_load_use;
    logic             w_rs1_hit;
    logic             w_rs2_hit;

    always_comb begin
        w_id            = '0;
        w_id.valid      = bus.i_idex_Valid;
        w_id.pc         = bus.i_idex_PC;
        w_id.rs1        = bus.i_idex_Rs1;
        w_id.rs2        = bus.i_idex_Rs2;
        w_id.rd         = bus.i_idex_Rd;
        w_id.rdata1     = bus.i_idex_RData1;
        w_id.rdata2     = bus.i_idex_RData2;
        w_id.imm        = bus.i_idex_Imm;
        w_id.alu_op     = bus.i_idex_AluOp;
        w_id.alu_src_b  = bus.i_idex_AluSrcB;
        w_id.reg_wr_en  = bus.i_idex_RegWrEn;
        w_id.mem_wr_en  = bus.i_idex_MemWrEn;
        w_id.mem_rd_en  = bus.i_idex_MemRdEn;
        w_id.mem_to_reg = bus.i_idex_MemToReg;
    end

    // A load into x0 never produces data anyone can depend on.
    assign w_rs1_hit  = bus.i_idex_UseRs1 && (bus.i_idex_Rs1 == r_stage.rd);
    assign w_rs2_hit  = bus.i_idex_UseRs2 && (bus.i_idex_Rs2 == r_stage.rd);
    assign w_load_use = !bus.i_idex_Flush && bus.i_idex_Valid && r_stage.valid &&
                        r_stage.mem_rd_en && (r_stage.rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    // Stall outranks load-use: hold without counting, hazard is re-evaluated afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage      <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.i_idex_Flush) begin
            r_stage <= '0;
        end else if (!bus.i_idex_Stall) begin
            if (w_load_use) begin
                r_stage <= '0;
                if (r_bubble_cnt != {CNT_W{1'b1}}) begin
                    r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
                end
            end else if (bus.i_idex_Valid) begin
                r_stage <= w_id;
            end else begin
                r_stage <= '0;
            end
        end
    end

    assign bus.o_idex_Valid     = r_stage.valid;
    assign bus.o_idex_PC        = r_stage.pc;
    assign bus.o_idex_Rs1       = r_stage.rs1;
    assign bus.o_idex_Rs2       = r_stage.rs2;
    assign bus.o_idex_Rd        = r_stage.rd;
    assign bus.o_idex_RData1    = r_stage.rdata1;
    assign bus.o_idex_RData2    = r_stage.rdata2;
    assign bus.o_idex_Imm       = r_stage.imm;
    assign bus.o_idex_AluOp     = r_stage.alu_op;
    assign bus.o_idex_AluSrcB   = r_stage.alu_src_b;
    assign bus.o_idex_RegWrEn   = r_stage.reg_wr_en;
    assign bus.o_idex_MemWrEn   = r_stage.mem_wr_en;
    assign bus.o_idex_MemRdEn   = r_stage.mem_rd_en;
    assign bus.o_idex_MemToReg  = r_stage.mem_to_reg;
    assign bus.o_idex_LoadUse   = w_load_use;
    assign bus.o_idex_StallID   = w_load_use | bus.i_idex_Stall;
    assign bus.o_idex_BubbleCnt = r_bubble_cnt;
endmodule

// File: tb/tb_idex_pipe.sv
// Directed bench for idex_pipe: a default-width instance plus a CNT_W=2
// instance sharing the same ID-side stimulus for the saturation check.
module tb_idex_pipe;
    logic i_clk = 1'b0;
    logic i_rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 i_clk = ~i_clk;

    idex_pipe_if #(.CNT_W(16)) ifa ();
    idex_pipe_if #(.CNT_W(2))  ifb ();

    idex_pipe #(.CNT_W(16)) u_dut (.i_clk(i_clk), .i_rst(i_rst), .bus(ifa));
    idex_pipe #(.CNT_W(2))  u_dut_sat (.i_clk(i_clk), .i_rst(i_rst), .bus(ifb));

    assign ifb.i_idex_Stall    = ifa.i_idex_Stall;
    assign ifb.i_idex_Flush    = ifa.i_idex_Flush;
    assign ifb.i_idex_Valid    = ifa.i_idex_Valid;
    assign ifb.i_idex_PC       = ifa.i_idex_PC;
    assign ifb.i_idex_Rs1      = ifa.i_idex_Rs1;
    assign ifb.i_idex_Rs2      = ifa.i_idex_Rs2;
    assign ifb.i_idex_Rd       = ifa.i_idex_Rd;
    assign ifb.i_idex_UseRs1   = ifa.i_idex_UseRs1;
    assign ifb.i_idex_UseRs2   = ifa.i_idex_UseRs2;
    assign ifb.i_idex_RData1   = ifa.i_idex_RData1;
    assign ifb.i_idex_RData2   = ifa.i_idex_RData2;
    assign ifb.i_idex_Imm      = ifa.i_idex_Imm;
    assign ifb.i_idex_AluOp    = ifa.i_idex_AluOp;
    assign ifb.i_idex_AluSrcB  = ifa.i_idex_AluSrcB;
    assign ifb.i_idex_RegWrEn  = ifa.i_idex_RegWrEn;
    assign ifb.i_idex_MemWrEn  = ifa.i_idex_MemWrEn;
    assign ifb.i_idex_MemRdEn  = ifa.i_idex_MemRdEn;
    assign ifb.i_idex_MemToReg = ifa.i_idex_MemToReg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic id_clear();
        ifa.i_idex_Valid    = 1'b0;
        ifa.i_idex_PC       = '0;
        ifa.i_idex_Rs1      = '0;
        ifa.i_idex_Rs2      = '0;
        ifa.i_idex_Rd       = '0;
        ifa.i_idex_UseRs1   = 1'b0;
        ifa.i_idex_UseRs2   = 1'b0;
        ifa.i_idex_RData1   = '0;
        ifa.i_idex_RData2   = '0;
        ifa.i_idex_Imm      = '0;
        ifa.i_idex_AluOp    = '0;
        ifa.i_idex_AluSrcB  = 1'b0;
        ifa.i_idex_RegWrEn  = 1'b0;
        ifa.i_idex_MemWrEn  = 1'b0;
        ifa.i_idex_MemRdEn  = 1'b0;
        ifa.i_idex_MemToReg = 1'b0;
    endtask

    // Valid register-writing instruction; loads also set MemToReg.
    task automatic id_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                            input logic memrd);
        id_clear();
        ifa.i_idex_Valid    = 1'b1;
        ifa.i_idex_PC       = pc;
        ifa.i_idex_Rs1      = rs1;
        ifa.i_idex_UseRs1   = u1;
        ifa.i_idex_Rs2      = rs2;
        ifa.i_idex_UseRs2   = u2;
        ifa.i_idex_Rd       = rd;
        ifa.i_idex_RegWrEn  = 1'b1;
        ifa.i_idex_MemRdEn  = memrd;
        ifa.i_idex_MemToReg = memrd;
    endtask

    initial begin
        i_rst = 1'b1;
        ifa.i_idex_Stall = 1'b0;
        ifa.i_idex_Flush = 1'b0;
        id_clear();
        #12;
        check("reset_valid", ifa.o_idex_Valid, 0);
        check("reset_cnt", ifa.o_idex_BubbleCnt, 0);
        i_rst = 1'b0;
        tick();

        // addi x5, x1, 3
        id_instr(32'h100, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0);
        ifa.i_idex_RData1  = 32'h10;
        ifa.i_idex_Imm     = 32'd3;
        ifa.i_idex_AluSrcB = 1'b1;
        ifa.i_idex_AluOp   = 4'd0;
        tick();
        check("pass_valid", ifa.o_idex_Valid, 1);
        check("pass_pc", ifa.o_idex_PC, 32'h100);
        check("pass_rd", ifa.o_idex_Rd, 5);
        check("pass_rdata1", ifa.o_idex_RData1, 32'h10);
        check("pass_imm", ifa.o_idex_Imm, 3);
        check("pass_srcb", ifa.o_idex_AluSrcB, 1);
        check("pass_regwr", ifa.o_idex_RegWrEn, 1);
        check("pass_loaduse", ifa.o_idex_LoadUse, 0);

        // lw x5 then add x6, x5, x7
        id_instr(32'h104, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        check("lw_in_ex_memrd", ifa.o_idex_MemRdEn, 1);
        id_instr(32'h108, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b0);
        ifa.i_idex_RData1 = 32'hAA;
        #1;
        check("lu_rs1_loaduse", ifa.o_idex_LoadUse, 1);
        check("lu_rs1_stallid", ifa.o_idex_StallID, 1);
        tick();
        check("lu_bubble_valid", ifa.o_idex_Valid, 0);
        check("lu_bubble_rd", ifa.o_idex_Rd, 0);
        check("lu_bubble_pc", ifa.o_idex_PC, 0);
        check("lu_cnt1", ifa.o_idex_BubbleCnt, 1);
        check("lu_drop", ifa.o_idex_LoadUse, 0);
        tick();
        check("lu_add_valid", ifa.o_idex_Valid, 1);
        check("lu_add_rs1", ifa.o_idex_Rs1, 5);
        check("lu_add_rd", ifa.o_idex_Rd, 6);
        check("lu_add_pc", ifa.o_idex_PC, 32'h108);
        check("lu_add_cnt", ifa.o_idex_BubbleCnt, 1);

        // Asynchronous reset between edges with a valid instruction loaded
        i_rst = 1'b1;
        #1;
        check("midrst_valid", ifa.o_idex_Valid, 0);
        check("midrst_pc", ifa.o_idex_PC, 0);
        check("midrst_rdata1", ifa.o_idex_RData1, 0);
        check("midrst_cnt", ifa.o_idex_BubbleCnt, 0);
        i_rst = 1'b0;

        // lw x0 followed by a reader of x0
        id_instr(32'h1FC, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
        tick();
        id_instr(32'h200, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b0);
        #1;
        check("x0_loaduse", ifa.o_idex_LoadUse, 0);
        tick();
        check("x0_pc", ifa.o_idex_PC, 32'h200);
        check("x0_cnt", ifa.o_idex_BubbleCnt, 0);

        // lw x5 followed by an instruction whose unused rs2 field is 5
        id_instr(32'h208, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        id_instr(32'h20C, 5'd1, 1'b1, 5'd5, 1'b0, 5'd8, 1'b0);
        #1;
        check("nouse_loaduse", ifa.o_idex_LoadUse, 0);
        tick();
        check("nouse_pc", ifa.o_idex_PC, 32'h20C);
        check("nouse_cnt", ifa.o_idex_BubbleCnt, 0);

        // Stall for three cycles with new ID data present
        id_instr(32'h300, 5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0);
        ifa.i_idex_Stall = 1'b1;
        #1;
        check("stall_stallid", ifa.o_idex_StallID, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", ifa.o_idex_PC, 32'h20C);
            check("stall_rd", ifa.o_idex_Rd, 8);
        end

        // Stall and flush together: flush wins
        ifa.i_idex_Flush = 1'b1;
        tick();
        check("stfl_valid", ifa.o_idex_Valid, 0);
        check("stfl_pc", ifa.o_idex_PC, 0);
        check("stfl_cnt", ifa.o_idex_BubbleCnt, 0);
        ifa.i_idex_Flush = 1'b0;
        ifa.i_idex_Stall = 1'b0;

        // Stall with a load-use hazard present
        id_instr(32'h400, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
        tick();
        id_instr(32'h404, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0);
        ifa.i_idex_Stall = 1'b1;
        #1;
        check("stlu_loaduse", ifa.o_idex_LoadUse, 1);
        check("stlu_stallid", ifa.o_idex_StallID, 1);
        tick();
        check("stlu_hold_pc", ifa.o_idex_PC, 32'h400);
        check("stlu_hold_memrd", ifa.o_idex_MemRdEn, 1);
        check("stlu_cnt", ifa.o_idex_BubbleCnt, 0);
        ifa.i_idex_Stall = 1'b0;
        #1;
        check("stlu_reeval", ifa.o_idex_LoadUse, 1);
        tick();
        check("stlu_bubble", ifa.o_idex_Valid, 0);
        check("stlu_cnt1", ifa.o_idex_BubbleCnt, 1);
        tick();
        check("stlu_enter_pc", ifa.o_idex_PC, 32'h404);

        // Saturation on the narrow instance
        i_rst = 1'b1;
        #2;
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            id_instr(32'h500 + 32'(i * 8), 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
            tick();
            id_instr(32'h504 + 32'(i * 8), 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0);
            #1;
            check("sat_loaduse", ifb.o_idex_LoadUse, 1);
            tick();
            check("sat_cnt2", ifb.o_idex_BubbleCnt, (i + 1 > 3) ? 3 : i + 1);
            check("sat_cnt16", ifa.o_idex_BubbleCnt, i + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
